subtype_check_seq: RTL

Sequencer that walks a bank of NUM_FIELDS subtype-constrained fields (a, b, c, ...) of a design under test, one field at a time. For each field it fetches the value, the expected value and the subtype bounds over a req/ack handshake, then checks the value. It sits between a regression bench top and a field-access responder, and reports an overall pass/fail verdict plus the first failing index and a failure count.

---
 rtl/subtype_check_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/subtype_check_seq.sv
// subtype_check_seq: fetches each field over req/ack and checks it against the expected value and its subtype bounds.
// Optional STOP_ON_FIRST_FAIL_EN macro ends the sequence at the first failing field.
module subtype_check_seq #(
  parameter int NUM_FIELDS = 5,
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fld_req,
  output logic [7:0]       fld_idx,
  input  logic             fld_ack,
  input  logic [WIDTH-1:0] fld_data,
  input  logic [WIDTH-1:0] fld_exp,
  input  logic [WIDTH-1:0] fld_lo,
  input  logic [WIDTH-1:0] fld_hi,
  output logic [7:0]       fail_idx,
  output logic [7:0]       fail_cnt,
  output logic             timeout
);
  typedef enum logic [2:0] {IDLE, REQ, CHECK, NEXT, FIN} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] LAST = 8'(NUM_FIELDS - 1);
`ifdef STOP_ON_FIRST_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic [WIDTH-1:0] r_data, r_exp, r_lo, r_hi;
  logic bad;
  logic [7:0] cnt_sat;
  assign bad = (r_data != r_exp) || (r_data < r_lo) || (r_data > r_hi);
  assign cnt_sat = (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fld_req <= 1'b0;
      fld_idx <= 8'd0;
      fail_idx <= 8'hFF;
      fail_cnt <= 8'd0;
      timeout <= 1'b0;
      wait_cnt <= '0;
      r_data <= '0;
      r_exp <= '0;
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          fld_req <= 1'b1;
          fld_idx <= 8'd0;
          fail_cnt <= 8'd0;
          fail_idx <= 8'hFF;
          timeout <= 1'b0;
          pass <= 1'b0;
          busy <= 1'b1;
          wait_cnt <= '0;
        end
        REQ: if (fld_ack) begin
          r_data <= fld_data;
          r_exp <= fld_exp;
          r_lo <= fld_lo;
          r_hi <= fld_hi;
          fld_req <= 1'b0;
          state <= CHECK;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          fld_req <= 1'b0;
          timeout <= 1'b1;
          fail_cnt <= cnt_sat;
          if (fail_idx == 8'hFF) fail_idx <= fld_idx;
          state <= STOP ? FIN : NEXT;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        CHECK: if (bad) begin
          fail_cnt <= cnt_sat;
          if (fail_idx == 8'hFF) fail_idx <= fld_idx;
          state <= STOP ? FIN : NEXT;
        end else begin
          state <= NEXT;
        end
        NEXT: begin
          wait_cnt <= '0;
          if (fld_idx == LAST) begin
            state <= FIN;
          end else begin
            fld_idx <= fld_idx + 8'd1;
            fld_req <= 1'b1;
            state <= REQ;
          end
        end
        FIN: begin
          done <= 1'b1;
          pass <= (fail_cnt == 8'd0);
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
